// File: rtl/matrix_scan_controller.sv
// Row-select sequencer for the 7x5 LED panel: double-buffered frame store,
// blank/show line scanning and a valid/ready frame loader.
module matrix_scan_controller #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load_valid,
    input  logic [34:0] load_data,
    output logic        load_ready,
    output logic [2:0]  sel,
    output logic [34:0] frame_out,
    output logic        frame_start
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [2:0]    LAST_LINE  = 3'd4;
    localparam logic [2:0]    SEL_OFF    = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     line_q, line_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [34:0]    pend_q, pend_d;
    logic           pend_full_q, pend_full_d;
    logic [34:0]    frame_q, frame_d;
    logic           frame_start_q, frame_start_d;
    logic           dwell_done;
    logic           blank_done;
    logic           frame_boundary;

    assign dwell_done     = (cnt_q == DWELL_LAST);
    assign blank_done     = (cnt_q == BLANK_LAST);
    assign frame_boundary = (state_q == SHOW) && dwell_done && (line_q == LAST_LINE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            line_q        <= 3'd0;
            cnt_q         <= '0;
            pend_q        <= '0;
            pend_full_q   <= 1'b0;
            frame_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            line_q        <= line_d;
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            pend_full_q   <= pend_full_d;
            frame_q       <= frame_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        line_d        = line_q;
        cnt_d         = cnt_q;
        pend_d        = pend_q;
        pend_full_d   = pend_full_q;
        frame_d       = frame_q;
        frame_start_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                line_d = 3'd0;
                if (enable) begin
                    state_d = BLANK;
                end
            end
            BLANK: begin
                if (blank_done) begin
                    state_d       = SHOW;
                    cnt_d         = '0;
                    frame_start_d = (line_q == 3'd0);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SHOW: begin
                if (dwell_done) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    line_d  = (line_q == LAST_LINE) ? 3'd0 : line_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                line_d  = 3'd0;
            end
        endcase

        // Disabling overrides any scan progress; re-enable restarts at line 0.
        if (!enable) begin
            state_d       = IDLE;
            line_d        = 3'd0;
            cnt_d         = '0;
            frame_start_d = 1'b0;
        end

        // Promotion needs a full slot and capture an empty one, so they never collide.
        if (pend_full_q && (frame_boundary || state_q == IDLE)) begin
            frame_d     = pend_q;
            pend_full_d = 1'b0;
        end else if (load_valid && !pend_full_q) begin
            pend_d      = load_data;
            pend_full_d = 1'b1;
        end
    end

    assign sel         = (state_q == SHOW) ? line_q : SEL_OFF;
    assign load_ready  = !pend_full_q;
    assign frame_out   = frame_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Directed bench for matrix_scan_controller with DWELL_CYCLES=4, BLANK_CYCLES=2
// (one line = 6 cycles, one frame = 30 cycles).
module tb_matrix_scan_controller;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        load_valid;
    logic [34:0] load_data;
    logic        load_ready;
    logic [2:0]  sel;
    logic [34:0] frame_out;
    logic        frame_start;

    int n_checks;
    int n_errors;
    int k;

    localparam logic [34:0] FRAME_A = 35'h0_0000_001F;
    localparam logic [34:0] FRAME_B = 35'h7_FFFF_FFFF;
    localparam logic [34:0] FRAME_X = 35'h0_0000_00AA;
    localparam logic [34:0] FRAME_C = 35'h5_5555_5555;

    matrix_scan_controller #(
        .DWELL_CYCLES(4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .sel         (sel),
        .frame_out   (frame_out),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Phase p within a 30-cycle frame: two blank cycles then four show cycles per line.
    function automatic logic [2:0] exp_sel(input int ph);
        int p;
        p = ph % 30;
        if ((p % 6) < 2) return 3'b111;
        return 3'(p / 6);
    endfunction

    task automatic idle_checks(input string tag, input logic [34:0] exp_frame);
        check({tag, "_sel"}, 64'(sel), 64'(3'b111));
        check({tag, "_frame_out"}, 64'(frame_out), 64'(exp_frame));
        check({tag, "_load_ready"}, 64'(load_ready), 64'(1'b1));
        check({tag, "_frame_start"}, 64'(frame_start), 64'(1'b0));
    endtask

    task automatic scan_step(input logic [34:0] exp_frame, input logic exp_ready);
        @(negedge clk);
        k++;
        check("scan_sel", 64'(sel), 64'(exp_sel(k)));
        check("scan_frame_start", 64'(frame_start), 64'((k % 30) == 2));
        check("scan_frame_out", 64'(frame_out), 64'(exp_frame));
        check("scan_load_ready", 64'(load_ready), 64'(exp_ready));
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        k          = -1;
        reset      = 1'b1;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;

        // Reset held, then released with scanning disabled.
        repeat (3) begin
            @(negedge clk);
            idle_checks("reset", 35'h0);
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            idle_checks("idle", 35'h0);
        end

        // Load while idle: one cycle of load_ready low, then promoted.
        load_valid = 1'b1;
        load_data  = FRAME_A;
        @(negedge clk);
        $display("load %09h accepted in IDLE", FRAME_A);
        check("idle_load_ready_low", 64'(load_ready), 64'(1'b0));
        check("idle_load_frame_old", 64'(frame_out), 64'(35'h0));
        load_valid = 1'b0;
        load_data  = '0;
        @(negedge clk);
        check("idle_load_ready_back", 64'(load_ready), 64'(1'b1));
        check("idle_load_frame_new", 64'(frame_out), 64'(FRAME_A));

        // Two full frames of scanning.
        k      = -1;
        enable = 1'b1;
        repeat (60) scan_step(FRAME_A, 1'b1);

        // Load during line 1; second offer while full must be ignored.
        repeat (9) scan_step(FRAME_A, 1'b1);
        load_valid = 1'b1;
        load_data  = FRAME_B;
        scan_step(FRAME_A, 1'b0);
        $display("load %09h accepted during line 1", FRAME_B);
        load_data = FRAME_X;
        repeat (11) scan_step(FRAME_A, 1'b0);
        load_valid = 1'b0;
        load_data  = '0;
        repeat (9) scan_step(FRAME_A, 1'b0);
        scan_step(FRAME_B, 1'b1);

        // Drop enable during SHOW of line 2, then re-enable.
        repeat (15) scan_step(FRAME_B, 1'b1);
        check("pre_disable_sel", 64'(sel), 64'(3'd2));
        enable = 1'b0;
        @(negedge clk);
        idle_checks("disable1", FRAME_B);
        @(negedge clk);
        idle_checks("disable2", FRAME_B);
        enable = 1'b1;
        k      = -1;
        repeat (3) scan_step(FRAME_B, 1'b1);

        // Pending frame during line 3 is discarded by reset.
        repeat (18) scan_step(FRAME_B, 1'b1);
        load_valid = 1'b1;
        load_data  = FRAME_C;
        scan_step(FRAME_B, 1'b0);
        $display("load %09h accepted during line 3", FRAME_C);
        load_valid = 1'b0;
        load_data  = '0;
        reset      = 1'b1;
        enable     = 1'b0;
        @(negedge clk);
        idle_checks("midframe_reset", 35'h0);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            idle_checks("post_reset", 35'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
